// File: rtl/frame_lookup_ctrl.sv
// -----------------------------------------------------------------------------
// frame_lookup_ctrl
//   Ingress-side controller in front of the MAC address table. It parses the
//   destination and source MAC from one port's byte stream, issues one learn
//   request and one lookup request per frame, and turns the table answer into
//   a unicast / flood / drop decision handed to the egress scheduler.
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   port_id_i            static ingress port number
//   rx_data_i/valid/last ingress byte stream; rx_ready_o accepts a byte
//   learn_req_o          one-cycle learn strobe with learn_address_o (src MAC)
//                        and learn_port_o (ingress port)
//   read_req_o           one-cycle lookup strobe with read_address_o (dst MAC)
//   read_port_i/valid_i  table result, valid one cycle after read_req_o
//   fwd_valid_o/ready_i  decision handshake; fwd_mask_o egress mask,
//                        fwd_drop_o frame discarded
//
// Build option:
//   FRAME_LOOKUP_STATS_EN  adds 16-bit saturating counters stat_frames_o,
//                          stat_flood_o, stat_drop_o and stat_runt_o.
// -----------------------------------------------------------------------------
module frame_lookup_ctrl #(
  parameter int NUM_PORTS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(NUM_PORTS)-1:0] port_id_i,
  input  logic [7:0]                   rx_data_i,
  input  logic                         rx_valid_i,
  input  logic                         rx_last_i,
  output logic                         rx_ready_o,
  output logic                         learn_req_o,
  output logic [47:0]                  learn_address_o,
  output logic [$clog2(NUM_PORTS)-1:0] learn_port_o,
  output logic                         read_req_o,
  output logic [47:0]                  read_address_o,
  input  logic [$clog2(NUM_PORTS)-1:0] read_port_i,
  input  logic                         read_port_valid_i,
  output logic                         fwd_valid_o,
  input  logic                         fwd_ready_i,
  output logic [NUM_PORTS-1:0]         fwd_mask_o,
  output logic                         fwd_drop_o
`ifdef FRAME_LOOKUP_STATS_EN
  ,
  output logic [15:0]                  stat_frames_o,
  output logic [15:0]                  stat_flood_o,
  output logic [15:0]                  stat_drop_o,
  output logic [15:0]                  stat_runt_o
`endif
);

  localparam int PW = $clog2(NUM_PORTS);

  localparam logic [2:0] ST_HDR    = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_RESP   = 3'd2;
  localparam logic [2:0] ST_OUT    = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;

  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  logic [2:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [47:0]          dst_q, dst_d;
  logic [47:0]          src_q, src_d;
  logic                 saw_last_q, saw_last_d;
  logic                 rx_ready_q, rx_ready_d;
  logic                 learn_req_q, learn_req_d;
  logic                 read_req_q, read_req_d;
  logic [PW-1:0]        learn_port_q, learn_port_d;
  logic                 fwd_valid_q, fwd_valid_d;
  logic [NUM_PORTS-1:0] fwd_mask_q, fwd_mask_d;
  logic                 fwd_drop_q, fwd_drop_d;
  logic                 accept_s;
  logic                 runt_s;
  logic                 handshake_s;

  assign accept_s    = rx_valid_i && rx_ready_q;
  assign handshake_s = (state_q == ST_OUT) && fwd_valid_q && fwd_ready_i;
  assign runt_s      = (state_q == ST_HDR) && accept_s && rx_last_i && (cnt_q < 4'd11);

  // Next-state, header capture and decision logic; every output is registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dst_d        = dst_q;
    src_d        = src_q;
    saw_last_d   = saw_last_q;
    rx_ready_d   = rx_ready_q;
    learn_req_d  = 1'b0;
    read_req_d   = 1'b0;
    learn_port_d = port_id_i;
    fwd_valid_d  = fwd_valid_q;
    fwd_mask_d   = fwd_mask_q;
    fwd_drop_d   = fwd_drop_q;
    case (state_q)
      ST_HDR: begin
        rx_ready_d = 1'b1;
        if (accept_s) begin
          if (cnt_q < 4'd6) begin
            dst_d = {dst_q[39:0], rx_data_i};
          end else begin
            src_d = {src_q[39:0], rx_data_i};
          end
          if (cnt_q == 4'd11) begin
            // Header complete: strobes appear in the LOOKUP cycle. Bit 40 is
            // the group bit (LSB of the first MAC byte); group addresses are
            // neither learned nor looked up.
            state_d     = ST_LOOKUP;
            cnt_d       = 4'd0;
            saw_last_d  = rx_last_i;
            rx_ready_d  = 1'b0;
            learn_req_d = ~src_d[40];
            read_req_d  = ~dst_q[40];
          end else if (rx_last_i) begin
            cnt_d = 4'd0;  // runt: discard silently
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_LOOKUP: begin
        rx_ready_d = 1'b0;
        state_d    = ST_RESP;
      end
      ST_RESP: begin
        rx_ready_d  = 1'b0;
        fwd_valid_d = 1'b1;
        state_d     = ST_OUT;
        if (dst_q[40] || !read_port_valid_i) begin
          fwd_mask_d = ~(ONE_HOT0 << port_id_i);
          fwd_drop_d = 1'b0;
        end else if (read_port_i == port_id_i) begin
          fwd_mask_d = {NUM_PORTS{1'b0}};
          fwd_drop_d = 1'b1;
        end else begin
          fwd_mask_d = ONE_HOT0 << read_port_i;
          fwd_drop_d = 1'b0;
        end
      end
      ST_OUT: begin
        if (handshake_s) begin
          fwd_valid_d = 1'b0;
          fwd_mask_d  = {NUM_PORTS{1'b0}};
          fwd_drop_d  = 1'b0;
          rx_ready_d  = 1'b1;
          state_d     = saw_last_q ? ST_HDR : ST_DRAIN;
        end else begin
          rx_ready_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        rx_ready_d = 1'b1;
        if (accept_s && rx_last_i) begin
          state_d = ST_HDR;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d     = ST_HDR;
        cnt_d       = 4'd0;
        rx_ready_d  = 1'b1;
        fwd_valid_d = 1'b0;
        fwd_mask_d  = {NUM_PORTS{1'b0}};
        fwd_drop_d  = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HDR;
      cnt_q        <= 4'd0;
      dst_q        <= 48'd0;
      src_q        <= 48'd0;
      saw_last_q   <= 1'b0;
      rx_ready_q   <= 1'b0;
      learn_req_q  <= 1'b0;
      read_req_q   <= 1'b0;
      learn_port_q <= {PW{1'b0}};
      fwd_valid_q  <= 1'b0;
      fwd_mask_q   <= {NUM_PORTS{1'b0}};
      fwd_drop_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dst_q        <= dst_d;
      src_q        <= src_d;
      saw_last_q   <= saw_last_d;
      rx_ready_q   <= rx_ready_d;
      learn_req_q  <= learn_req_d;
      read_req_q   <= read_req_d;
      learn_port_q <= learn_port_d;
      fwd_valid_q  <= fwd_valid_d;
      fwd_mask_q   <= fwd_mask_d;
      fwd_drop_q   <= fwd_drop_d;
    end
  end

  assign rx_ready_o      = rx_ready_q;
  assign learn_req_o     = learn_req_q;
  assign learn_address_o = src_q;
  assign learn_port_o    = learn_port_q;
  assign read_req_o      = read_req_q;
  assign read_address_o  = dst_q;
  assign fwd_valid_o     = fwd_valid_q;
  assign fwd_mask_o      = fwd_mask_q;
  assign fwd_drop_o      = fwd_drop_q;

`ifdef FRAME_LOOKUP_STATS_EN
  logic        flood_q, flood_d;
  logic [15:0] frames_q, flood_cnt_q, drop_cnt_q, runt_cnt_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Remember whether the pending decision is a flood.
  always_comb begin
    if (state_q == ST_RESP) begin
      flood_d = dst_q[40] || !read_port_valid_i;
    end else begin
      flood_d = flood_q;
    end
  end

  // Saturating decision and runt counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flood_q     <= 1'b0;
      frames_q    <= 16'd0;
      flood_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
      runt_cnt_q  <= 16'd0;
    end else begin
      flood_q <= flood_d;
      if (handshake_s) begin
        frames_q <= sat_inc(frames_q);
        if (flood_q)    flood_cnt_q <= sat_inc(flood_cnt_q);
        if (fwd_drop_q) drop_cnt_q  <= sat_inc(drop_cnt_q);
      end
      if (runt_s) runt_cnt_q <= sat_inc(runt_cnt_q);
    end
  end

  assign stat_frames_o = frames_q;
  assign stat_flood_o  = flood_cnt_q;
  assign stat_drop_o   = drop_cnt_q;
  assign stat_runt_o   = runt_cnt_q;
`else
  logic unused_runt_s;
  assign unused_runt_s = runt_s;
`endif

endmodule

// File: tb/tb_frame_lookup_ctrl.sv
module tb_frame_lookup_ctrl;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    port_id_i;
  logic [7:0]    rx_data_i;
  logic          rx_valid_i;
  logic          rx_last_i;
  logic          rx_ready_o;
  logic          learn_req_o;
  logic [47:0]   learn_address_o;
  logic [1:0]    learn_port_o;
  logic          read_req_o;
  logic [47:0]   read_address_o;
  logic [1:0]    read_port_i;
  logic          read_port_valid_i;
  logic          fwd_valid_o;
  logic          fwd_ready_i;
  logic [NP-1:0] fwd_mask_o;
  logic          fwd_drop_o;

  int checks   = 0;
  int failures = 0;

  frame_lookup_ctrl #(.NUM_PORTS(NP)) dut (
    .clk(clk), .rst(rst), .port_id_i(port_id_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_last_i(rx_last_i),
    .rx_ready_o(rx_ready_o),
    .learn_req_o(learn_req_o), .learn_address_o(learn_address_o), .learn_port_o(learn_port_o),
    .read_req_o(read_req_o), .read_address_o(read_address_o),
    .read_port_i(read_port_i), .read_port_valid_i(read_port_valid_i),
    .fwd_valid_o(fwd_valid_o), .fwd_ready_i(fwd_ready_i),
    .fwd_mask_o(fwd_mask_o), .fwd_drop_o(fwd_drop_o)
  );

  always #5 clk = ~clk;

  // Byte i of a frame: 12 header bytes MSB first, then filler payload.
  function automatic logic [7:0] frame_byte(input logic [47:0] d, input logic [47:0] s, input int i);
    logic [95:0] hdr;
    hdr = {d, s};
    if (i < 12) return hdr[95-8*i -: 8];
    return 8'(i * 7 + 3);
  endfunction

  // Reference decision {drop, mask} from the forwarding rules.
  function automatic logic [NP:0] ref_decision(input logic [47:0] d, input logic [1:0] port,
                                               input logic hit, input logic [1:0] tport);
    logic [NP-1:0] all_ones;
    all_ones = 4'hF;
    if (d[40] || !hit) return {1'b0, all_ones & ~(4'(1) << port)};
    if (tport == port) return {1'b1, 4'h0};
    return {1'b0, 4'(1) << tport};
  endfunction

  task automatic run_frame(input logic [47:0] d, input logic [47:0] s, input logic [1:0] port,
                           input logic hit, input logic [1:0] tport, input int len, input int stall);
    logic [NP:0] exp;
    logic        exp_learn, exp_read;
    exp       = ref_decision(d, port, hit, tport);
    exp_learn = ~s[40];
    exp_read  = ~d[40];
    port_id_i = port;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (rx_ready_o !== 1'b1) begin failures++; $display("FAIL hdr_ready byte %0d: got %b expected 1", i, rx_ready_o); end
      rx_valid_i = 1'b1;
      rx_data_i  = frame_byte(d, s, i);
      rx_last_i  = (i == len - 1);
      @(posedge clk); @(negedge clk);
    end
    // Cycle T+1: strobes.
    if (len > 12) begin
      rx_data_i = frame_byte(d, s, 12);
      rx_last_i = (len == 13);
    end else begin
      rx_valid_i = 1'b0;
      rx_last_i  = 1'b0;
    end
    checks++;
    if (learn_req_o !== exp_learn) begin failures++; $display("FAIL learn_req: got %b expected %b", learn_req_o, exp_learn); end
    checks++;
    if (read_req_o !== exp_read) begin failures++; $display("FAIL read_req: got %b expected %b", read_req_o, exp_read); end
    if (exp_learn) begin
      checks++;
      if (learn_address_o !== s || learn_port_o !== port) begin
        failures++; $display("FAIL learn_addr: got %h/%0d expected %h/%0d", learn_address_o, learn_port_o, s, port);
      end
    end
    if (exp_read) begin
      checks++;
      if (read_address_o !== d) begin failures++; $display("FAIL read_addr: got %h expected %h", read_address_o, d); end
    end
    checks++;
    if (rx_ready_o !== 1'b0 || fwd_valid_o !== 1'b0) begin
      failures++; $display("FAIL lookup_idle: got ready=%b valid=%b expected 0/0", rx_ready_o, fwd_valid_o);
    end
    @(posedge clk); @(negedge clk);
    // Cycle T+2: table answers the lookup issued one cycle earlier.
    read_port_valid_i = exp_read && hit;
    read_port_i       = tport;
    checks++;
    if (learn_req_o !== 1'b0 || read_req_o !== 1'b0 || fwd_valid_o !== 1'b0) begin
      failures++; $display("FAIL resp_cycle: got learn=%b read=%b valid=%b expected 0/0/0", learn_req_o, read_req_o, fwd_valid_o);
    end
    @(posedge clk); @(negedge clk);
    // Cycle T+3: decision presented.
    read_port_valid_i = 1'b0;
    read_port_i       = 2'($urandom);
    checks++;
    if (fwd_valid_o !== 1'b1 || fwd_mask_o !== exp[NP-1:0] || fwd_drop_o !== exp[NP]) begin
      failures++; $display("FAIL decision: got v=%b mask=%b drop=%b expected v=1 mask=%b drop=%b",
                           fwd_valid_o, fwd_mask_o, fwd_drop_o, exp[NP-1:0], exp[NP]);
    end
    for (int k = 0; k < stall; k++) begin
      fwd_ready_i = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (fwd_valid_o !== 1'b1 || fwd_mask_o !== exp[NP-1:0] || fwd_drop_o !== exp[NP] || rx_ready_o !== 1'b0) begin
        failures++; $display("FAIL stall_hold %0d: got v=%b mask=%b drop=%b ready=%b expected v=1 mask=%b drop=%b ready=0",
                             k, fwd_valid_o, fwd_mask_o, fwd_drop_o, rx_ready_o, exp[NP-1:0], exp[NP]);
      end
    end
    fwd_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    fwd_ready_i = 1'b0;
    checks++;
    if (fwd_valid_o !== 1'b0 || rx_ready_o !== 1'b1) begin
      failures++; $display("FAIL post_handshake: got valid=%b ready=%b expected 0/1", fwd_valid_o, rx_ready_o);
    end
    for (int i = 12; i < len; i++) begin
      rx_valid_i = 1'b1;
      rx_data_i  = frame_byte(d, s, i);
      rx_last_i  = (i == len - 1);
      @(posedge clk); @(negedge clk);
      checks++;
      if (fwd_valid_o !== 1'b0 || learn_req_o !== 1'b0 || read_req_o !== 1'b0 || rx_ready_o !== 1'b1) begin
        failures++; $display("FAIL drain byte %0d: got v=%b l=%b r=%b ready=%b expected 0/0/0/1",
                             i, fwd_valid_o, learn_req_o, read_req_o, rx_ready_o);
      end
    end
    rx_valid_i = 1'b0;
    rx_last_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; port_id_i = 2'd0; rx_data_i = 8'd0; rx_valid_i = 1'b0; rx_last_i = 1'b0;
    read_port_i = 2'd0; read_port_valid_i = 1'b0; fwd_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_ready_o, learn_req_o, read_req_o, fwd_valid_o, fwd_drop_o} !== 5'b0 || fwd_mask_o !== 4'h0 ||
        learn_address_o !== 48'h0 || read_address_o !== 48'h0 || learn_port_o !== 2'd0) begin
      failures++; $display("FAIL reset_outputs: got ready=%b l=%b r=%b v=%b mask=%b expected all 0",
                           rx_ready_o, learn_req_o, read_req_o, fwd_valid_o, fwd_mask_o);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (rx_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", rx_ready_o); end
  endtask

  task automatic test_unicast();
    run_frame(48'h001122334455, 48'h00AA00000001, 2'd0, 1'b1, 2'd2, 12, 0);
  endtask

  task automatic test_miss();
    run_frame(48'h001122334455, 48'h00AA00000001, 2'd1, 1'b0, 2'd2, 12, 0);
  endtask

  task automatic test_broadcast();
    run_frame(48'hFFFFFFFFFFFF, 48'h00AA00000002, 2'd3, 1'b1, 2'd0, 12, 0);
  endtask

  task automatic test_local_filter();
    run_frame(48'h0002B3000010, 48'h00AA00000003, 2'd1, 1'b1, 2'd1, 12, 0);
    run_frame(48'h0002B3000011, 48'h01005E000001, 2'd2, 1'b1, 2'd0, 14, 1);
  endtask

  task automatic test_runt_backpressure();
    port_id_i = 2'd2;
    for (int i = 0; i < 8; i++) begin
      rx_valid_i = 1'b1;
      rx_data_i  = 8'(8'h40 + i);
      rx_last_i  = (i == 7);
      @(posedge clk); @(negedge clk);
    end
    rx_valid_i = 1'b0;
    rx_last_i  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (learn_req_o !== 1'b0 || read_req_o !== 1'b0 || fwd_valid_o !== 1'b0 || rx_ready_o !== 1'b1) begin
        failures++; $display("FAIL runt_quiet %0d: got l=%b r=%b v=%b ready=%b expected 0/0/0/1",
                             k, learn_req_o, read_req_o, fwd_valid_o, rx_ready_o);
      end
      @(posedge clk); @(negedge clk);
    end
    run_frame(48'h00C0FFEE0001, 48'h00BEEF000002, 2'd2, 1'b1, 2'd3, 12, 0);
    run_frame(48'h00C0FFEE0003, 48'h00BEEF000004, 2'd0, 1'b1, 2'd1, 64, 5);
  endtask

  task automatic test_reset_midframe();
    port_id_i = 2'd1;
    for (int i = 0; i < 10; i++) begin
      rx_valid_i = 1'b1;
      rx_data_i  = 8'(8'h90 + i);
      rx_last_i  = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    rx_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({rx_ready_o, learn_req_o, read_req_o, fwd_valid_o, fwd_drop_o} !== 5'b0 || fwd_mask_o !== 4'h0) begin
      failures++; $display("FAIL midframe_reset: got ready=%b l=%b r=%b v=%b expected all 0",
                           rx_ready_o, learn_req_o, read_req_o, fwd_valid_o);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    run_frame(48'h00DDEEFF0011, 48'h002233440055, 2'd1, 1'b1, 2'd3, 12, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(48'h000000000A0A, 48'h000000000B0B, 2'd3, 1'b1, 2'd0, 12, 0);
    run_frame(48'h010000000A0A, 48'h000000000C0C, 2'd0, 1'b0, 2'd0, 12, 0);
  endtask

  task automatic test_random();
    logic [47:0] d, s;
    for (int n = 0; n < 30; n++) begin
      d = {16'($urandom), $urandom};
      s = {16'($urandom), $urandom};
      if ($urandom_range(0, 7) == 0) d = 48'hFFFFFFFFFFFF;
      run_frame(d, s, 2'($urandom), 1'($urandom), 2'($urandom),
                $urandom_range(12, 20), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_miss();
    test_broadcast();
    test_local_filter();
    test_runt_backpressure();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_lookup_ctrl.md
Name: frame_lookup_ctrl

Overview:
- Ingress-side controller placed directly upstream of the MAC address table.
- Accepts one ingress port's frame byte stream and extracts the destination MAC (bytes 0-5) and source MAC (bytes 6-11).
- Issues one learn request and one read request per frame to the address table, then converts the table response into a per-frame forwarding decision: unicast, flood or drop.
- Passes the decision to the egress scheduler through a valid/ready handshake, then drains the rest of the frame.

Parameters:
- NUM_PORTS, 4: switch port count. Sets the width of port IDs ($clog2(NUM_PORTS)) and of the egress mask (NUM_PORTS).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- port_id_i  input  $clog2(NUM_PORTS)  ingress port number; static.
- rx_data_i  input  8  frame byte, first byte = destination MAC MSB.
- rx_valid_i  input  1  rx_data_i valid.
- rx_last_i  input  1  current byte is the last byte of the frame.
- rx_ready_o  output  1  byte accepted when rx_valid_i && rx_ready_o.
- learn_req_o  output  1  one-cycle learn strobe to the address table.
- learn_address_o  output  48  source MAC.
- learn_port_o  output  $clog2(NUM_PORTS)  equals port_id_i.
- read_req_o  output  1  one-cycle lookup strobe.
- read_address_o  output  48  destination MAC.
- read_port_i  input  $clog2(NUM_PORTS)  table result port.
- read_port_valid_i  input  1  table hit, registered one cycle after read_req_o.
- fwd_valid_o  output  1  decision valid.
- fwd_ready_i  input  1  downstream accepts the decision.
- fwd_mask_o  output  NUM_PORTS  egress port mask.
- fwd_drop_o  output  1  frame to be discarded (mask is 0).

Behaviour:
- Reset: all outputs 0, state HDR, byte counter 0. The next accepted byte after reset is byte 0 of a new frame.
- Reset mid-frame or mid-handshake: the decision is lost and no strobe is emitted.
- Byte counter: 4 bits, counts accepted bytes 0..11.
  - Bytes 0-5 shift into the dst register; bytes 6-11 shift into the src register (MSB first).
- State HDR:
  - rx_ready_o=1.
  - rx_last_i on byte index < 11 (runt): discard, no strobes, counter cleared, stay in HDR.
  - Byte 11 accepted at cycle T: go to LOOKUP. Also latch saw_last = rx_last_i.
- State LOOKUP (cycle T+1), rx_ready_o=0:
  - learn_req_o=1 unless src bit 40 (multicast/group bit) is set.
  - read_req_o=1 unless dst bit 40 is set.
  - Address and port outputs are valid together with the strobes; both strobes last exactly one cycle.
  - Go to RESP.
- State RESP (cycle T+2): sample read_port_valid_i.
  - dst group bit set, or no hit: flood. fwd_mask_o = all ones with bit port_id_i cleared; fwd_drop_o=0.
  - Hit and read_port_i != port_id_i: fwd_mask_o = one-hot(read_port_i).
  - Hit and read_port_i == port_id_i: fwd_mask_o=0, fwd_drop_o=1 (local traffic filter).
  - Go to OUT.
- State OUT (from T+3):
  - fwd_valid_o=1; mask and drop stay stable until the handshake.
  - On fwd_valid_o && fwd_ready_i: go to HDR if saw_last, else DRAIN.
  - fwd_valid_o deasserts in the cycle after the handshake.
- State DRAIN:
  - rx_ready_o=1; accepted bytes are ignored.
  - Byte with rx_last_i accepted: go to HDR, counter 0.
- Latency: last header byte accepted at T -> strobes at T+1 -> fwd_valid_o at T+3. With fwd_ready_i held high the minimum frame-to-frame spacing is 12 header bytes + 3 cycles.
- rx_ready_o=0 in LOOKUP, RESP and OUT. Upstream must hold data.
- Same-cycle learn and read of the same MAC (src==dst) are both issued; the table resolves ordering.

Optional Feature:
- Macro: FRAME_LOOKUP_STATS_EN.
- Defined: adds outputs stat_frames_o, stat_flood_o, stat_drop_o, stat_runt_o, each 16 bits.
  - stat_frames_o, stat_flood_o and stat_drop_o increment on each decision handshake of the matching type (frames counts all).
  - stat_runt_o increments on each runt discard.
  - All counters saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Unicast hit: port_id_i=0, dst=00:11:22:33:44:55, src=00:AA:00:00:00:01, table returns port 2 with valid -> learn/read strobes one cycle after byte 11; fwd_mask_o=4'b0100, fwd_drop_o=0, fwd_valid_o 3 cycles after byte 11.
- Miss: same frame with read_port_valid_i=0 on port_id_i=1 -> fwd_mask_o=4'b1101.
- Broadcast: dst=FF:FF:FF:FF:FF:FF from port 3 -> read_req_o stays 0, learn_req_o=1, fwd_mask_o=4'b0111.
- Local filter: hit returns port 1 on port_id_i=1 -> fwd_mask_o=0, fwd_drop_o=1. Multicast src 01:00:5E:00:00:01 -> learn_req_o stays 0.
- Runt and backpressure: 8-byte frame with rx_last_i on byte 7 -> no strobes, no fwd_valid_o, next frame parsed correctly. Then a 64-byte frame with fwd_ready_i=0 for 5 cycles -> mask held stable, rx_ready_o=0 throughout, then drain to rx_last_i.
- Reset mid-frame: assert rst after byte 9 -> all outputs 0 immediately; a following full frame produces a correct decision.
